rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It fetches an instruction into the instruction register and classifies the opcode. It then drives the immediate-generator type select, ALU operand selects, memory strobes, register write-enable and PC update through a FETCH→DECODE→EXEC→MEM→WB sequence. It sits between instruction/data memory handshakes and the structural datapath: register file, immediate generator, ALU and branch comparator.

## Interface
No parameters.
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction memory read data; sampled when imem_ack=1 in FETCH
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete / instr valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  1=store, 0=load; valid while dmem_req=1
- dmem_ack  in  1  data access complete
- branch_taken  in  1  branch comparator result for IR's funct3
- ir  out  32  instruction register
- imm_sel  out  3  0=I,1=S,2=B,3=U,4=J; combinational from ir
- alu_src_a  out  2  0=rs1,1=pc,2=zero
- alu_src_b  out  1  0=rs2,1=imm
- wb_sel  out  2  0=ALU,1=load data,2=pc+4
- reg_we  out  1  register file write strobe
- pc_we  out  1  PC update strobe
- pc_src  out  2  0=pc+4,1=pc+imm,2=ALU result & ~1
- retired  out  1  one-cycle pulse, equal to pc_we
- illegal  out  1  high in TRAP

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1 until imem_ack. On ack, ir<=instr and go to DECODE. Otherwise hold.
- DECODE: one cycle. If opcode is not one of the nine below, go to TRAP. This includes ir[1:0]!=2'b11. Otherwise go to EXEC.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- imm_sel per opcode:
  - U for LUI and AUIPC.
  - J for JAL.
  - I for JALR, LOAD and OP-IMM.
  - S for STORE.
  - B for BRANCH.
  - 0 for OP and for any illegal opcode.
- alu_src_a per opcode: 2 for LUI, 1 for AUIPC, 0 otherwise.
- alu_src_b per opcode: 0 for OP and BRANCH, 1 otherwise.
- EXEC transitions:
  - BRANCH: pc_we=1; pc_src=1 if branch_taken, else 0. Go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: dmem_req=1, with dmem_we=1 for STORE. Hold until dmem_ack.
  - STORE on ack: pc_we=1, pc_src=0, go to FETCH.
  - LOAD on ack: go to WB.
- WB: reg_we=1 unless ir[11:7]==0. pc_we=1. Go to FETCH.
  - wb_sel: 2 for JAL/JALR, 1 for LOAD, 0 otherwise.
  - pc_src: 1 for JAL, 2 for JALR, 0 otherwise.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until rst.
- Strobes (imem_req, dmem_req, reg_we, pc_we) are asserted only in the states listed above; they are 0 everywhere else.
- Select outputs are don't-care when not consumed, but must still follow the decode rules above.

## Timing
- Strobes are combinational from state plus ir plus the ack inputs (Mealy on ack, as noted above). There is no registered output latency.
- Reset, while rst=1 at a clock edge:
  - Next state is FETCH.
  - ir <= 32'h0000_0013 (NOP).
  - All strobes and illegal are forced to 0 during the rst cycle.
- Reset mid-operation aborts the current instruction with no writes. After reset, the first active cycle asserts imem_req.
- Cycle counts with zero-wait acks (ack in the first request cycle):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each ack wait cycle adds 1.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- An ack in the same cycle as rst is ignored.
- ir changes only on a FETCH ack or on reset.
- dmem_we is stable for the whole MEM state.

## Test plan
- Reset/first fetch:
  - Stimulus: rst high 2 cycles, then low, imem_ack=0 for 3 cycles.
  - Required: ir=0x00000013 and imem_req=0 during reset; imem_req=1 held for 3 cycles; no pc_we.
- ADDI x1,x0,5 (0x00500093) with immediate ack:
  - Required: FETCH, DECODE, EXEC, WB.
  - In WB: reg_we=1, wb_sel=0, pc_we=1, pc_src=0; imm_sel=0 and alu_src_b=1 throughout.
- LW (0x0000A103) with dmem_ack delayed 2 cycles:
  - Required: dmem_req=1 and dmem_we=0 for 3 cycles; then WB with wb_sel=1, reg_we=1; 7 cycles total.
- BEQ (0x00000463):
  - Required: imm_sel=2.
  - With branch_taken=1: pc_we=1, pc_src=1 in EXEC, 3 cycles, reg_we never asserted.
  - With branch_taken=0: pc_src=0.
- JALR x0,0(x1) (0x00008067):
  - Required: imm_sel=0; in WB reg_we=0 (rd=0), pc_src=2, wb_sel=2.
- Illegal instruction 0xFFFFFFFF:
  - Required: TRAP after DECODE; illegal=1, all strobes 0 for 10+ cycles.
  - Then rst: illegal=0 and FETCH resumes.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_ctrl
// Description : Multi-cycle control FSM for the RV32I core. Fetches an
//               instruction into the instruction register, classifies the
//               opcode, and sequences FETCH -> DECODE -> EXEC -> MEM -> WB,
//               driving datapath selects and memory / register / PC strobes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   core clock, rising edge
//   rst          in   1   synchronous active-high reset
//   instr        in  32   instruction memory read data
//   imem_req     out  1   instruction fetch request
//   imem_ack     in   1   fetch complete / instr valid
//   dmem_req     out  1   data memory request
//   dmem_we      out  1   1=store, 0=load
//   dmem_ack     in   1   data access complete
//   branch_taken in   1   branch comparator result
//   ir           out 32   instruction register
//   imm_sel      out  3   0=I 1=S 2=B 3=U 4=J
//   alu_src_a    out  2   0=rs1 1=pc 2=zero
//   alu_src_b    out  1   0=rs2 1=imm
//   wb_sel       out  2   0=ALU 1=load data 2=pc+4
//   reg_we       out  1   register file write strobe
//   pc_we        out  1   PC update strobe
//   pc_src       out  2   0=pc+4 1=pc+imm 2=ALU&~1
//   retired      out  1   instruction retire pulse (equals pc_we)
//   illegal      out  1   high while trapped on an illegal opcode
// ============================================================================
module rv_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic [31:0] ir,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        retired,
    output logic        illegal
);

    // Opcodes (full 7 bits, so ir[1:0] != 2'b11 never matches)
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_TRAP   = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_ir;

    logic [6:0] w_opc;
    logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic       w_is_load, w_is_store, w_is_opimm, w_is_op;
    logic       w_legal;
    logic       w_rd_nz;

    assign w_opc       = r_ir[6:0];
    assign w_is_lui    = (w_opc == c_OPC_LUI);
    assign w_is_auipc  = (w_opc == c_OPC_AUIPC);
    assign w_is_jal    = (w_opc == c_OPC_JAL);
    assign w_is_jalr   = (w_opc == c_OPC_JALR);
    assign w_is_branch = (w_opc == c_OPC_BRANCH);
    assign w_is_load   = (w_opc == c_OPC_LOAD);
    assign w_is_store  = (w_opc == c_OPC_STORE);
    assign w_is_opimm  = (w_opc == c_OPC_OPIMM);
    assign w_is_op     = (w_opc == c_OPC_OP);
    assign w_legal     = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                         w_is_load | w_is_store | w_is_opimm | w_is_op;
    assign w_rd_nz     = (r_ir[11:7] != 5'd0);

    // ------------------------------------------------------------------------
    // State and instruction register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
            r_ir    <= c_NOP;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= instr;
                        r_state <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    r_state <= w_legal ? c_ST_EXEC : c_ST_TRAP;
                end
                c_ST_EXEC: begin
                    if (w_is_branch)
                        r_state <= c_ST_FETCH;
                    else if (w_is_load || w_is_store)
                        r_state <= c_ST_MEM;
                    else
                        r_state <= c_ST_WB;
                end
                c_ST_MEM: begin
                    if (dmem_ack)
                        r_state <= w_is_store ? c_ST_FETCH : c_ST_WB;
                end
                c_ST_WB: begin
                    r_state <= c_ST_FETCH;
                end
                c_ST_TRAP: begin
                    r_state <= c_ST_TRAP;
                end
                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

    assign ir = r_ir;

    // ------------------------------------------------------------------------
    // Datapath selects: decoded purely from the instruction register so they
    // stay stable for the whole instruction.
    // ------------------------------------------------------------------------
    always_comb begin
        imm_sel   = 3'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b1;
        wb_sel    = 2'd0;
        pc_src    = 2'd0;

        if (w_is_lui || w_is_auipc)
            imm_sel = 3'd3;
        else if (w_is_jal)
            imm_sel = 3'd4;
        else if (w_is_store)
            imm_sel = 3'd1;
        else if (w_is_branch)
            imm_sel = 3'd2;

        if (w_is_lui)
            alu_src_a = 2'd2;
        else if (w_is_auipc)
            alu_src_a = 2'd1;

        if (w_is_op || w_is_branch)
            alu_src_b = 1'b0;

        if (w_is_jal || w_is_jalr)
            wb_sel = 2'd2;
        else if (w_is_load)
            wb_sel = 2'd1;

        // Branch target only when the comparator says taken; store and other
        // non-jump retirements fall through to pc+4.
        if (w_is_branch)
            pc_src = branch_taken ? 2'd1 : 2'd0;
        else if (w_is_jal)
            pc_src = 2'd1;
        else if (w_is_jalr)
            pc_src = 2'd2;
    end

    // ------------------------------------------------------------------------
    // Strobes: Mealy on the ack inputs, all forced low during reset so an
    // aborted instruction performs no writes.
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        illegal  = 1'b0;

        if (!rst) begin
            case (r_state)
                c_ST_FETCH:  imem_req = 1'b1;
                c_ST_EXEC:   pc_we    = w_is_branch;
                c_ST_MEM: begin
                    dmem_req = 1'b1;
                    pc_we    = w_is_store & dmem_ack;
                end
                c_ST_WB: begin
                    reg_we = w_rd_nz;
                    pc_we  = 1'b1;
                end
                c_ST_TRAP:   illegal  = 1'b1;
                default:     ;
            endcase
        end
    end

    // Depends only on ir, so it cannot change during a MEM wait.
    assign dmem_we = w_is_store;
    assign retired = pc_we;

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_multicycle_ctrl
// Description : Directed self-checking bench for rv_multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        branch_taken;
    logic [31:0] ir;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        retired;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // Per-cycle snapshot; strobes packed as {imem_req, dmem_req, reg_we, pc_we}
    logic [3:0]  s_strb;
    logic        s_dmem_we, s_illegal, s_retired, s_b;
    logic [2:0]  s_imm;
    logic [1:0]  s_a, s_wb, s_pcs;
    logic [31:0] s_ir;

    rv_multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .ir           (ir),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .wb_sel       (wb_sel),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .retired      (retired),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    // Drive inputs for one cycle, snapshot outputs at the falling edge, then
    // move to just after the next rising edge.
    task automatic step(input logic ia, input logic da, input logic bt);
        imem_ack     = ia;
        dmem_ack     = da;
        branch_taken = bt;
        @(negedge clk);
        s_strb    = {imem_req, dmem_req, reg_we, pc_we};
        s_dmem_we = dmem_we;
        s_illegal = illegal;
        s_retired = retired;
        s_imm     = imm_sel;
        s_a       = alu_src_a;
        s_b       = alu_src_b;
        s_wb      = wb_sel;
        s_pcs     = pc_src;
        s_ir      = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        instr = 32'hDEAD_BEEF;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (s_ir !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reset_ir got %h exp %h", s_ir, 32'h0000_0013);
        end
        checks++;
        if (s_strb !== 4'b0000 || s_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b/%b exp 0000/0", s_strb, s_illegal);
        end
        rst   = 1'b0;
        instr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (s_strb !== 4'b1000 || s_ir !== 32'h0000_0013) begin
                errors++;
                $display("FAIL first_fetch[%0d] got strb %b ir %h exp 1000 00000013", i, s_strb, s_ir);
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0] exp_s [5];
        exp_s = '{4'b1000, 4'b0000, 4'b0000, 4'b0011, 4'b1000};
        instr = 32'h0050_0093;
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 1'b0, 1'b0);
            checks++;
            if (s_strb !== exp_s[i] || s_imm !== 3'd0 || s_b !== 1'b1) begin
                errors++;
                $display("FAIL addi[%0d] got strb %b imm %0d b %b exp %b 0 1", i, s_strb, s_imm, s_b, exp_s[i]);
            end
            if (i == 1) begin
                checks++;
                if (s_ir !== 32'h0050_0093) begin
                    errors++;
                    $display("FAIL addi_ir got %h exp 00500093", s_ir);
                end
            end
            if (i == 3) begin
                checks++;
                if (s_wb !== 2'd0 || s_pcs !== 2'd0 || s_retired !== 1'b1) begin
                    errors++;
                    $display("FAIL addi_wb got wb %0d pcs %0d ret %b exp 0 0 1", s_wb, s_pcs, s_retired);
                end
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] exp_s [8];
        exp_s = '{4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0011, 4'b1000};
        instr = 32'h0000_A103;
        for (int i = 0; i < 8; i++) begin
            step(i == 0, i == 5, 1'b0);
            checks++;
            if (s_strb !== exp_s[i]) begin
                errors++;
                $display("FAIL load[%0d] strb got %b exp %b", i, s_strb, exp_s[i]);
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (s_dmem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL load_we[%0d] got %b exp 0", i, s_dmem_we);
                end
            end
            if (i == 6) begin
                checks++;
                if (s_wb !== 2'd1 || s_imm !== 3'd0) begin
                    errors++;
                    $display("FAIL load_wb got wb %0d imm %0d exp 1 0", s_wb, s_imm);
                end
            end
        end
    endtask

    task automatic test_store();
        logic [3:0] exp_s [5];
        exp_s = '{4'b1000, 4'b0000, 4'b0000, 4'b0101, 4'b1000};
        instr = 32'h0020_A023;
        for (int i = 0; i < 5; i++) begin
            step(i == 0, i == 3, 1'b0);
            checks++;
            if (s_strb !== exp_s[i]) begin
                errors++;
                $display("FAIL store[%0d] strb got %b exp %b", i, s_strb, exp_s[i]);
            end
            if (i == 3) begin
                checks++;
                if (s_dmem_we !== 1'b1 || s_pcs !== 2'd0 || s_imm !== 3'd1) begin
                    errors++;
                    $display("FAIL store_mem got we %b pcs %0d imm %0d exp 1 0 1", s_dmem_we, s_pcs, s_imm);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] exp_s [4];
        exp_s = '{4'b1000, 4'b0000, 4'b0001, 4'b1000};
        instr = 32'h0000_0463;
        for (int t = 1; t >= 0; t--) begin
            for (int i = 0; i < 4; i++) begin
                step(i == 0, 1'b0, t[0]);
                checks++;
                if (s_strb !== exp_s[i]) begin
                    errors++;
                    $display("FAIL branch_t%0d[%0d] strb got %b exp %b", t, i, s_strb, exp_s[i]);
                end
                if (i == 1) begin
                    checks++;
                    if (s_imm !== 3'd2 || s_b !== 1'b0) begin
                        errors++;
                        $display("FAIL branch_sel got imm %0d b %b exp 2 0", s_imm, s_b);
                    end
                end
                if (i == 2) begin
                    checks++;
                    if (s_pcs !== 2'(t)) begin
                        errors++;
                        $display("FAIL branch_pcsrc_t%0d got %0d exp %0d", t, s_pcs, t);
                    end
                end
            end
        end
    endtask

    typedef struct packed {
        logic [31:0] ins;
        logic [2:0]  imm;
        logic [1:0]  a;
        logic        b;
        logic [1:0]  wb;
        logic [1:0]  pcs;
        logic [3:0]  wbs;
    } wb_vec_t;

    task automatic test_writeback_ops();
        wb_vec_t    tbl [5];
        logic [3:0] exp_s [5];
        tbl[0] = '{32'h0020_81B3, 3'd0, 2'd0, 1'b0, 2'd0, 2'd0, 4'b0011}; // ADD x3
        tbl[1] = '{32'h1234_50B7, 3'd3, 2'd2, 1'b1, 2'd0, 2'd0, 4'b0011}; // LUI x1
        tbl[2] = '{32'h0000_0097, 3'd3, 2'd1, 1'b1, 2'd0, 2'd0, 4'b0011}; // AUIPC x1
        tbl[3] = '{32'h0080_00EF, 3'd4, 2'd0, 1'b1, 2'd2, 2'd1, 4'b0011}; // JAL x1
        tbl[4] = '{32'h0000_8067, 3'd0, 2'd0, 1'b1, 2'd2, 2'd2, 4'b0001}; // JALR x0
        for (int k = 0; k < 5; k++) begin
            instr = tbl[k].ins;
            exp_s = '{4'b1000, 4'b0000, 4'b0000, tbl[k].wbs, 4'b1000};
            for (int i = 0; i < 5; i++) begin
                step(i == 0, 1'b0, 1'b0);
                checks++;
                if (s_strb !== exp_s[i]) begin
                    errors++;
                    $display("FAIL wbop%0d[%0d] strb got %b exp %b", k, i, s_strb, exp_s[i]);
                end
                if (i == 1) begin
                    checks++;
                    if (s_imm !== tbl[k].imm || s_a !== tbl[k].a || s_b !== tbl[k].b) begin
                        errors++;
                        $display("FAIL wbop%0d_sel got imm %0d a %0d b %b exp %0d %0d %b",
                                 k, s_imm, s_a, s_b, tbl[k].imm, tbl[k].a, tbl[k].b);
                    end
                end
                if (i == 3) begin
                    checks++;
                    if (s_wb !== tbl[k].wb || s_pcs !== tbl[k].pcs) begin
                        errors++;
                        $display("FAIL wbop%0d_wb got wb %0d pcs %0d exp %0d %0d",
                                 k, s_wb, s_pcs, tbl[k].wb, tbl[k].pcs);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        instr = 32'h0050_0093;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (s_strb !== 4'b0000) begin
            errors++;
            $display("FAIL abort_strobes got %b exp 0000", s_strb);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (s_strb !== 4'b1000 || s_ir !== 32'h0000_0013) begin
            errors++;
            $display("FAIL abort_refetch got strb %b ir %h exp 1000 00000013", s_strb, s_ir);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad = '{32'hFFFF_FFFF, 32'h0000_0030};
        for (int k = 0; k < 2; k++) begin
            instr = bad[k];
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (s_strb !== 4'b0000 || s_illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_decode got strb %b ill %b exp 0000 0", k, s_strb, s_illegal);
            end
            // Acks and instruction changes must be ignored while trapped.
            instr = 32'h0050_0093;
            for (int i = 0; i < 12; i++) begin
                step(1'b1, 1'b1, 1'b1);
                checks++;
                if (s_strb !== 4'b0000 || s_illegal !== 1'b1 || s_ir !== bad[k]) begin
                    errors++;
                    $display("FAIL illegal%0d_trap[%0d] got strb %b ill %b ir %h exp 0000 1 %h",
                             k, i, s_strb, s_illegal, s_ir, bad[k]);
                end
            end
            rst = 1'b1;
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (s_strb !== 4'b0000 || s_illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_rst got strb %b ill %b exp 0000 0", k, s_strb, s_illegal);
            end
            rst = 1'b0;
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (s_strb !== 4'b1000 || s_illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_resume got strb %b ill %b exp 1000 0", k, s_strb, s_illegal);
            end
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        instr        = 32'h0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        branch_taken = 1'b0;

        test_reset();
        test_addi();
        test_load();
        test_store();
        test_branch();
        test_writeback_ops();
        test_reset_abort();
        test_illegal();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
